// File: rtl/dm_ctrl_multi_pkg.sv
`default_nettype none
// DM: shared debug-module types (abstract command error codes, controller state).
package DM;

  typedef enum logic [2:0] {
    CmdErrNone         = 3'd0,
    CmdErrBusy         = 3'd1,
    CmdErrNotSupported = 3'd2,
    CmdErrException    = 3'd3,
    CmdErrHaltResume   = 3'd4,
    CmdErrBus          = 3'd5,
    CmdErrOther        = 3'd7
  } cmderr_e;

  typedef enum logic [1:0] {
    DmIdle = 2'd0,
    DmGo   = 2'd1,
    DmRes  = 2'd2,
    DmExec = 2'd3
  } dm_ctrl_state_e;

endpackage
`default_nettype wire

// File: rtl/dm_timeout_cnt.sv
`default_nettype none
// dm_timeout_cnt: saturating cycle counter; expired_o flags the last allowed cycle.
module dm_timeout_cnt #(
  parameter int TimeoutCycles = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CNT_W = $clog2(TimeoutCycles);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TimeoutCycles - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired_o = (r_cnt == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/dm_ctrl_multi.sv
`default_nettype none
// dm_ctrl_multi: abstract-command / resume handshake controller shared by NrHarts harts,
// one operation in flight, with timeout abort and prioritised single-cycle error pulses.
module dm_ctrl_multi
  import DM::*;
#(
  parameter int NrHarts       = 4,
  parameter int TimeoutCycles = 1024,
  localparam int HartSelW     = (NrHarts > 1) ? $clog2(NrHarts) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cmd_valid_i,
  input  logic                unsupported_cmd_i,
  input  logic [HartSelW-1:0] hartsel_i,
  input  logic                resumereq_i,
  input  logic                haltreq_i,
  input  logic                ndmreset_i,
  input  logic [NrHarts-1:0]  halted_i,
  input  logic [NrHarts-1:0]  going_i,
  input  logic [NrHarts-1:0]  resuming_i,
  input  logic [NrHarts-1:0]  exception_i,
  input  logic [NrHarts-1:0]  halted_int_i,
  output logic [NrHarts-1:0]  go_o,
  output logic [NrHarts-1:0]  resume_o,
  output logic [NrHarts-1:0]  debug_req_o,
  output logic                cmdbusy_o,
  output logic                cmderror_valid_o,
  output cmderr_e             cmderror_o,
  output logic [HartSelW-1:0] active_hart_o
);

  dm_ctrl_state_e      r_state, w_state_d;
  logic [HartSelW-1:0] r_active;
  logic                w_latch;
  logic                w_expired;
  logic                w_sel_valid;
  logic                w_sel_halted;
  logic                w_sel_resuming;
  cmderr_e             w_err;

  assign w_sel_valid    = (int'(hartsel_i) < NrHarts);
  assign w_sel_halted   = w_sel_valid && halted_i[hartsel_i];
  assign w_sel_resuming = w_sel_valid && resuming_i[hartsel_i];
  assign cmdbusy_o      = (r_state != DmIdle);

  // Held clear while idle, so every operation starts counting from zero.
  dm_timeout_cnt #(
    .TimeoutCycles(TimeoutCycles)
  ) u_timeout (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    ((r_state == DmIdle) || ndmreset_i),
    .en_i     (cmdbusy_o),
    .expired_o(w_expired)
  );

  // Later assignments to w_err override earlier ones, giving the error priority order.
  always_comb begin
    w_state_d = r_state;
    w_err     = CmdErrNone;
    w_latch   = 1'b0;
    case (r_state)
      DmIdle: begin
        if (cmd_valid_i) begin
          if (unsupported_cmd_i) begin
            w_err = CmdErrNotSupported;
          end else if (!w_sel_halted) begin
            w_err = CmdErrHaltResume;
          end else begin
            w_state_d = DmGo;
            w_latch   = 1'b1;
          end
        end
        if ((w_state_d == DmIdle) && resumereq_i && !haltreq_i &&
            w_sel_halted && !w_sel_resuming) begin
          w_state_d = DmRes;
          w_latch   = 1'b1;
        end
      end
      DmGo: begin
        if (cmd_valid_i) w_err = CmdErrBusy;
        if (w_expired) begin
          w_err     = CmdErrOther;
          w_state_d = DmIdle;
        end else if (going_i[r_active]) begin
          w_state_d = DmExec;
        end
      end
      DmRes: begin
        if (cmd_valid_i) w_err = CmdErrBusy;
        if (w_expired) begin
          w_err     = CmdErrOther;
          w_state_d = DmIdle;
        end else if (resuming_i[r_active]) begin
          w_state_d = DmIdle;
        end
      end
      DmExec: begin
        if (cmd_valid_i) w_err = CmdErrBusy;
        if (exception_i[r_active]) begin
          w_err     = CmdErrException;
          w_state_d = DmIdle;
        end else if (w_expired) begin
          w_err     = CmdErrOther;
          w_state_d = DmIdle;
        end else if (halted_int_i[r_active]) begin
          w_state_d = DmIdle;
        end
      end
      default: w_state_d = DmIdle;
    endcase
    if (ndmreset_i) begin
      w_state_d = DmIdle;
      w_err     = CmdErrNone;
      w_latch   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state  <= DmIdle;
      r_active <= '0;
    end else begin
      r_state <= w_state_d;
      if (w_latch) r_active <= hartsel_i;
    end
  end

  always_comb begin
    go_o        = '0;
    resume_o    = '0;
    debug_req_o = '0;
    for (int h = 0; h < NrHarts; h++) begin
      go_o[h]        = (r_state == DmGo) && !ndmreset_i && (r_active == HartSelW'(h));
      resume_o[h]    = (r_state == DmRes) && !ndmreset_i && (r_active == HartSelW'(h));
      debug_req_o[h] = rst_ni && haltreq_i && (hartsel_i == HartSelW'(h));
    end
  end

  assign cmderror_o       = rst_ni ? w_err : CmdErrNone;
  assign cmderror_valid_o = (cmderror_o != CmdErrNone);
  assign active_hart_o    = r_active;

endmodule
`default_nettype wire

// File: tb/tb_dm_ctrl_multi.sv
`default_nettype none
// Bench for dm_ctrl_multi: vector table, directed multi-cycle sequences, and random
// stimulus against an operation-level reference model.
module tb_dm_ctrl_multi;

  localparam int N  = 4;
  localparam int TC = 8;
  localparam logic [2:0] E_NONE = 3'd0, E_BUSY = 3'd1, E_NSUP = 3'd2,
                         E_EXC  = 3'd3, E_HR   = 3'd4, E_OTHER = 3'd7;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cmd_valid, unsup, resumereq, haltreq, ndmreset;
  logic [1:0]   hartsel;
  logic [N-1:0] halted, going, resuming, exception, halted_int;
  logic [N-1:0] go, resume, dbg;
  logic         busy, errv;
  logic [2:0]   err;
  logic [1:0]   active;

  logic       c3_cmd_valid, c3_haltreq;
  logic [1:0] c3_hartsel;
  logic [2:0] c3_halted, c3_go, c3_resume, c3_dbg;
  logic       c3_busy, c3_errv;
  logic [2:0] c3_err;
  logic [1:0] c3_active;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dm_ctrl_multi #(.NrHarts(N), .TimeoutCycles(TC)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(cmd_valid), .unsupported_cmd_i(unsup),
    .hartsel_i(hartsel), .resumereq_i(resumereq), .haltreq_i(haltreq), .ndmreset_i(ndmreset),
    .halted_i(halted), .going_i(going), .resuming_i(resuming), .exception_i(exception),
    .halted_int_i(halted_int), .go_o(go), .resume_o(resume), .debug_req_o(dbg),
    .cmdbusy_o(busy), .cmderror_valid_o(errv), .cmderror_o(err), .active_hart_o(active)
  );

  dm_ctrl_multi #(.NrHarts(3), .TimeoutCycles(TC)) u_dut3 (
    .clk_i(clk), .rst_ni(rst_n), .cmd_valid_i(c3_cmd_valid), .unsupported_cmd_i(1'b0),
    .hartsel_i(c3_hartsel), .resumereq_i(1'b0), .haltreq_i(c3_haltreq), .ndmreset_i(1'b0),
    .halted_i(c3_halted), .going_i(3'b000), .resuming_i(3'b000), .exception_i(3'b000),
    .halted_int_i(3'b000), .go_o(c3_go), .resume_o(c3_resume), .debug_req_o(c3_dbg),
    .cmdbusy_o(c3_busy), .cmderror_valid_o(c3_errv), .cmderror_o(c3_err),
    .active_hart_o(c3_active)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; unsup = 0; resumereq = 0; haltreq = 0; ndmreset = 0; hartsel = 0;
    halted = 0; going = 0; resuming = 0; exception = 0; halted_int = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: an operation is "none", "command" (before/after going ack) or "resume".
  int m_op = 0;
  bit m_ran = 0;
  int m_age = 0;
  int m_hart = 0;

  task automatic model_step(input int cyc);
    logic [3:0] e_go, e_res, e_dbg;
    logic [2:0] e_err;
    bit e_busy;
    int hs, n_op, n_hart;
    bit n_ran;
    hs = int'(hartsel);
    e_go = 0; e_res = 0; e_err = E_NONE;
    e_dbg = haltreq ? (4'b0001 << hs) : 4'b0000;
    e_busy = (m_op != 0);
    if (e_busy && !ndmreset) begin
      if (m_op == 1 && !m_ran) e_go = 4'b0001 << m_hart;
      if (m_op == 2) e_res = 4'b0001 << m_hart;
    end
    n_op = m_op; n_ran = m_ran; n_hart = m_hart;
    if (e_busy) begin
      if (cmd_valid) e_err = E_BUSY;
      if (m_op == 1 && m_ran && exception[m_hart]) begin
        e_err = E_EXC; n_op = 0;
      end else if (m_age == TC - 1) begin
        e_err = E_OTHER; n_op = 0;
      end else if (m_op == 1 && !m_ran && going[m_hart]) begin
        n_ran = 1;
      end else if (m_op == 1 && m_ran && halted_int[m_hart]) begin
        n_op = 0;
      end else if (m_op == 2 && resuming[m_hart]) begin
        n_op = 0;
      end
    end else begin
      if (cmd_valid && unsup) e_err = E_NSUP;
      else if (cmd_valid && !halted[hs]) e_err = E_HR;
      else if (cmd_valid) begin n_op = 1; n_ran = 0; n_hart = hs; end
      if (n_op == 0 && resumereq && !haltreq && halted[hs] && !resuming[hs]) begin
        n_op = 2; n_hart = hs;
      end
    end
    if (ndmreset) begin e_err = E_NONE; n_op = 0; end
    chk($sformatf("rnd%0d go", cyc), go, e_go);
    chk($sformatf("rnd%0d resume", cyc), resume, e_res);
    chk($sformatf("rnd%0d dbg", cyc), dbg, e_dbg);
    chk($sformatf("rnd%0d busy", cyc), busy, e_busy);
    chk($sformatf("rnd%0d errv", cyc), errv, e_err != E_NONE);
    chk($sformatf("rnd%0d err", cyc), err, e_err);
    if (e_busy) chk($sformatf("rnd%0d active", cyc), active, m_hart);
    m_age  = (m_op != 0 && n_op != 0) ? m_age + 1 : 0;
    m_op   = n_op;
    m_ran  = n_ran;
    m_hart = n_hart;
  endtask

  typedef struct packed {
    logic cv, un, rr, hr;
    logic [1:0] hs;
    logic [3:0] halted, resuming, e_dbg;
    logic [2:0] e_err;
    logic e_busy;
  } vec_t;

  vec_t vt[10];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0] = '{cv:1, un:1, rr:0, hr:0, hs:0, halted:4'hF, resuming:0, e_dbg:0, e_err:E_NSUP, e_busy:0};
    vt[1] = '{cv:1, un:0, rr:0, hr:0, hs:1, halted:4'hD, resuming:0, e_dbg:0, e_err:E_HR, e_busy:0};
    vt[2] = '{cv:1, un:1, rr:0, hr:0, hs:1, halted:4'hD, resuming:0, e_dbg:0, e_err:E_NSUP, e_busy:0};
    vt[3] = '{cv:0, un:0, rr:0, hr:1, hs:3, halted:4'h0, resuming:0, e_dbg:4'h8, e_err:E_NONE, e_busy:0};
    vt[4] = '{cv:0, un:0, rr:1, hr:1, hs:0, halted:4'hF, resuming:0, e_dbg:4'h1, e_err:E_NONE, e_busy:0};
    vt[5] = '{cv:0, un:0, rr:1, hr:0, hs:2, halted:4'h4, resuming:4'h4, e_dbg:0, e_err:E_NONE, e_busy:0};
    vt[6] = '{cv:0, un:0, rr:1, hr:0, hs:2, halted:4'h3, resuming:0, e_dbg:0, e_err:E_NONE, e_busy:0};
    vt[7] = '{cv:0, un:0, rr:1, hr:0, hs:2, halted:4'h4, resuming:0, e_dbg:0, e_err:E_NONE, e_busy:1};
    vt[8] = '{cv:1, un:0, rr:0, hr:0, hs:3, halted:4'h8, resuming:0, e_dbg:0, e_err:E_NONE, e_busy:1};
    vt[9] = '{cv:1, un:1, rr:1, hr:0, hs:1, halted:4'h2, resuming:0, e_dbg:0, e_err:E_NSUP, e_busy:1};

    idle_inputs();
    c3_cmd_valid = 0; c3_haltreq = 0; c3_hartsel = 0; c3_halted = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset go", go, 0);
    chk("reset resume", resume, 0);
    chk("reset dbg", dbg, 0);
    chk("reset busy", busy, 0);
    chk("reset errv", errv, 0);
    chk("reset err", err, E_NONE);
    chk("reset active", active, 0);
    rst_n = 1;
    next_cycle();

    // Single-cycle decisions taken from idle.
    for (int i = 0; i < 10; i++) begin
      cmd_valid = vt[i].cv; unsup = vt[i].un; resumereq = vt[i].rr; haltreq = vt[i].hr;
      hartsel = vt[i].hs; halted = vt[i].halted; resuming = vt[i].resuming;
      @(negedge clk);
      chk($sformatf("vec%0d dbg", i), dbg, vt[i].e_dbg);
      chk($sformatf("vec%0d errv", i), errv, vt[i].e_err != E_NONE);
      chk($sformatf("vec%0d err", i), err, vt[i].e_err);
      next_cycle();
      idle_inputs();
      @(negedge clk);
      chk($sformatf("vec%0d busy", i), busy, vt[i].e_busy);
      ndmreset = 1;
      next_cycle();
      ndmreset = 0;
    end

    // Abstract command on hart 2: GO, busy error while busy, EXEC, completion.
    halted = 4'b0100; hartsel = 2; cmd_valid = 1;
    @(negedge clk);
    chk("cmd2 accept errv", errv, 0);
    next_cycle();
    cmd_valid = 0;
    @(negedge clk);
    chk("cmd2 go", go, 4'b0100);
    chk("cmd2 busy", busy, 1);
    chk("cmd2 active", active, 2);
    next_cycle();
    going = 4'b0100; cmd_valid = 1; hartsel = 0;
    @(negedge clk);
    chk("cmd2 busy err", err, E_BUSY);
    chk("cmd2 go held", go, 4'b0100);
    next_cycle();
    going = 0; cmd_valid = 0;
    @(negedge clk);
    chk("cmd2 exec go", go, 0);
    chk("cmd2 exec busy", busy, 1);
    halted_int = 4'b0100;
    next_cycle();
    halted_int = 0;
    @(negedge clk);
    chk("cmd2 done busy", busy, 0);

    // Timeout in GO.
    halted = 4'b0001; hartsel = 0; cmd_valid = 1;
    next_cycle();
    cmd_valid = 0;
    for (int k = 1; k <= TC; k++) begin
      @(negedge clk);
      chk($sformatf("tmo errv c%0d", k), errv, k == TC);
      chk($sformatf("tmo go c%0d", k), go, 4'b0001);
      if (k == TC) chk("tmo err", err, E_OTHER);
      next_cycle();
    end
    @(negedge clk);
    chk("tmo after busy", busy, 0);
    chk("tmo after go", go, 0);
    chk("tmo after errv", errv, 0);

    // Exception beats busy in EXEC on hart 3.
    halted = 4'b1000; hartsel = 3; cmd_valid = 1;
    next_cycle();
    cmd_valid = 0; going = 4'b1000;
    next_cycle();
    going = 0; cmd_valid = 1; exception = 4'b1000;
    @(negedge clk);
    chk("exc errv", errv, 1);
    chk("exc err", err, E_EXC);
    next_cycle();
    cmd_valid = 0; exception = 0;
    @(negedge clk);
    chk("exc idle busy", busy, 0);
    chk("exc single pulse", errv, 0);

    // Resume on hart 0, completed; then resume aborted by ndmreset.
    halted = 4'b0001; hartsel = 0; resumereq = 1;
    next_cycle();
    resumereq = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("res hold c%0d", k), resume, 4'b0001);
      next_cycle();
    end
    resuming = 4'b0001;
    @(negedge clk);
    chk("res ack resume", resume, 4'b0001);
    next_cycle();
    resuming = 0;
    @(negedge clk);
    chk("res done busy", busy, 0);
    chk("res done resume", resume, 0);
    resumereq = 1;
    next_cycle();
    resumereq = 0;
    @(negedge clk);
    chk("ndm pre resume", resume, 4'b0001);
    ndmreset = 1; cmd_valid = 1;
    #1;
    chk("ndm resume", resume, 0);
    chk("ndm errv", errv, 0);
    next_cycle();
    ndmreset = 0; cmd_valid = 0;
    @(negedge clk);
    chk("ndm busy", busy, 0);

    // Asynchronous reset mid-operation.
    halted = 4'b0010; hartsel = 1; cmd_valid = 1;
    next_cycle();
    cmd_valid = 0;
    @(negedge clk);
    chk("arst pre busy", busy, 1);
    rst_n = 0;
    #1;
    chk("arst busy", busy, 0);
    chk("arst go", go, 0);
    chk("arst active", active, 0);
    #1;
    rst_n = 1;
    next_cycle();
    @(negedge clk);
    chk("arst post busy", busy, 0);
    chk("arst post errv", errv, 0);

    // Non-power-of-two hart count: out-of-range selection.
    c3_halted = 3'b111; c3_hartsel = 3; c3_cmd_valid = 1; c3_haltreq = 1;
    @(negedge clk);
    chk("h3 oor dbg", c3_dbg, 0);
    chk("h3 oor errv", c3_errv, 1);
    chk("h3 oor err", c3_err, E_HR);
    next_cycle();
    c3_cmd_valid = 0; c3_hartsel = 2;
    @(negedge clk);
    chk("h3 busy", c3_busy, 0);
    chk("h3 go", c3_go | c3_resume, 0);
    chk("h3 dbg", c3_dbg, 3'b100);
    chk("h3 active", c3_active, 0);
    c3_haltreq = 0;

    // Random stimulus against the reference model.
    idle_inputs();
    next_cycle();
    m_op = 0; m_ran = 0; m_age = 0; m_hart = 0;
    for (int c = 0; c < 500; c++) begin
      cmd_valid  = ($urandom_range(0, 3) == 0);
      unsup      = ($urandom_range(0, 3) == 0);
      resumereq  = ($urandom_range(0, 3) == 0);
      haltreq    = ($urandom_range(0, 3) == 0);
      ndmreset   = ($urandom_range(0, 39) == 0);
      hartsel    = 2'($urandom_range(0, 3));
      halted     = 4'($urandom) | 4'($urandom);
      going      = 4'($urandom) & 4'($urandom);
      resuming   = 4'($urandom) & 4'($urandom);
      halted_int = 4'($urandom) & 4'($urandom);
      exception  = 4'($urandom) & 4'($urandom) & 4'($urandom);
      @(negedge clk);
      model_step(c);
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dm_ctrl_multi.md
DM_CTRL_MULTI -- requirements
Module: dm_ctrl_multi

Interface
REQ-001 SHALL have parameter NrHarts, default 4, meaning number of harts served (1..32).
REQ-002 SHALL have parameter TimeoutCycles, default 1024, meaning max cycles in GO/RES/EXEC before abort (>=2).
REQ-003 SHALL have ports clk_i (in, 1, clock) and rst_ni (in, 1, reset); one clock, reset asynchronous, active-low.
REQ-004 SHALL have ports cmd_valid_i (in, 1, abstract command request) and unsupported_cmd_i (in, 1, command not supported).
REQ-005 SHALL have port hartsel_i (in, HartSelW = max(1, clog2(NrHarts)), selected hart index).
REQ-006 SHALL have ports resumereq_i, haltreq_i and ndmreset_i (in, 1 each; dmcontrol fields, apply to hartsel_i).
REQ-007 SHALL have per-hart inputs halted_i, going_i, resuming_i, exception_i and halted_int_i (in, NrHarts each, bit h = hart h).
REQ-008 SHALL have per-hart outputs go_o, resume_o and debug_req_o (out, NrHarts each, one-hot or zero).
REQ-009 SHALL have outputs cmdbusy_o (out, 1), cmderror_valid_o (out, 1, single-cycle error pulse) and cmderror_o (out, DM::cmderr_e).
REQ-010 SHALL have output active_hart_o (out, HartSelW, hart latched for the current operation).

Function
REQ-011 SHALL implement FSM states IDLE, GO, RES, EXEC; one operation in flight across all harts.
REQ-012 IDLE: on cmd_valid_i with hartsel_i < NrHarts, halted_i[hartsel_i]=1 and unsupported_cmd_i=0 -> latch hartsel_i into active hart, next GO.
REQ-013 IDLE: on cmd_valid_i with unsupported_cmd_i=1 -> pulse error NotSupported; stay IDLE.
REQ-014 IDLE: on cmd_valid_i with target not halted or hartsel_i >= NrHarts -> pulse error HaltResume; stay IDLE.
REQ-015 IDLE: on resumereq_i with haltreq_i=0, halted_i[sel]=1 and resuming_i[sel]=0 -> latch sel, next RES; an accepted command takes priority over resume in the same cycle.
REQ-016 GO: assert go_o[active]; on going_i[active] -> EXEC.
REQ-017 EXEC: outputs idle; on halted_int_i[active] -> IDLE.
REQ-018 RES: assert resume_o[active]; on resuming_i[active] -> IDLE.
REQ-019 cmdbusy_o SHALL be 1 in GO, RES and EXEC, and 0 in IDLE.
REQ-020 cmd_valid_i while cmdbusy_o=1 SHALL pulse error Busy; state unaffected.
REQ-021 SHALL hold a saturating timeout counter, cleared on entry to GO/RES and incremented each cycle in GO/RES/EXEC.
REQ-022 On reaching TimeoutCycles-1 the FSM SHALL go to IDLE, pulse error Other, and deassert go_o/resume_o next cycle.
REQ-023 exception_i[active] in EXEC SHALL pulse error Exception and move to IDLE.
REQ-024 Error priority in one cycle SHALL be: Exception > Other(timeout) > Busy > NotSupported > HaltResume; exactly one code per pulse.
REQ-025 debug_req_o SHALL be combinational: bit hartsel_i = haltreq_i, other bits 0, with hartsel_i >= NrHarts giving all bits 0.
REQ-026 ndmreset_i SHALL force next state IDLE and zero go_o/resume_o combinationally, suppress errors in that cycle, and clear the counter.
REQ-027 When no error pulse, cmderror_o SHALL be DM::None.

Reset
REQ-028 On rst_ni=0, state SHALL be IDLE, counter 0 and active hart 0; all outputs 0, cmderror_o None.
REQ-029 Reset asserted mid-operation SHALL abort immediately with no error pulse after release.

Structure
REQ-030 DM::cmderr_e SHALL be reused from package DM; the FSM state enum SHALL be defined in package DM as dm_ctrl_state_e.
REQ-031 The timeout counter SHALL be a sub-module dm_timeout_cnt (parameter TimeoutCycles; inputs clr, en; output expired).

Verification
REQ-032 Hart 2 halted, cmd_valid_i with hartsel_i=2 -> next cycle go_o=4'b0100, cmdbusy_o=1; going_i[2] -> EXEC; halted_int_i[2] -> IDLE, cmdbusy_o=0.
REQ-033 Hart 1 running, cmd_valid_i with hartsel_i=1 -> same-cycle cmderror_valid_o=1 with HaltResume; state IDLE.
REQ-034 TimeoutCycles=8, GO with going_i held 0 -> error Other after 8 busy cycles, then IDLE and go_o=0.
REQ-035 EXEC on hart 3 with cmd_valid_i and exception_i[3] in the same cycle -> single pulse Exception, then IDLE.
REQ-036 resumereq_i on hart 0 halted -> resume_o=4'b0001 until resuming_i[0]; ndmreset_i mid-RES -> resume_o=0 in the same cycle, IDLE next.
